imem_responder: RTL and testbench

Instruction-memory responder for the fetch stage: the far end of the fetch request interface. It accepts one instruction-fetch request at a time, returns the 32-bit instruction word after a fixed latency, and reports the instruction-address-misaligned and instruction-access-fault conditions that feed fetch's exception wires. It also offers a word-wide load port for program download by the bench or boot logic.

---
 rtl/imem_responder.sv | 133 +++++++++++++
 tb/tb_imem_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch in flight, response LATENCY edges after acceptance,
// RV32I misaligned/access-fault flags, plus a word-wide load port for program download.
module imem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  input  logic [31:0]                    req_addr_i,
  output logic                           req_ready_o,
  input  logic                           flush_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [31:0]                    rsp_pc_o,
  output logic [31:0]                    rsp_instr_o,
  output logic                           rsp_iam_o,
  output logic                           rsp_iaf_o,
  input  logic                           ld_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr_i,
  input  logic [31:0]                    ld_data_i
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_pc_q;
  logic [31:0] rsp_instr_q;
  logic        rsp_iam_q;
  logic        rsp_iaf_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  // 33-bit range check so BASE_ADDR + 4*DEPTH_WORDS never wraps.
  logic [32:0] addr_ext;
  logic [32:0] base_ext;
  logic [32:0] end_ext;
  logic        iam_d;
  logic        iaf_d;
  logic [31:0] rd_word;

  assign addr_ext = {1'b0, rsp_pc_q};
  assign base_ext = {1'b0, BASE_ADDR};
  assign end_ext  = base_ext + (33'(DEPTH_WORDS) << 2);
  assign iam_d    = |rsp_pc_q[1:0];
  assign iaf_d    = !iam_d && ((addr_ext < base_ext) || (addr_ext >= end_ext));
  assign rd_word  = mem_q[AW'((rsp_pc_q - BASE_ADDR) >> 2)];

  // Memory is never reset; a write on the response edge leaves the old word in rsp_instr.
  always_ff @(posedge clk_i) begin
    if (ld_we_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= 32'd0;
      rsp_instr_q <= 32'd0;
      rsp_iam_q   <= 1'b0;
      rsp_iaf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q && !flush_i) begin
            rsp_pc_q    <= req_addr_i;
            cnt_q       <= 4'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_iam_q   <= 1'b0;
            rsp_iaf_q   <= 1'b0;
          end else if (cnt_q == 4'd0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_iam_q   <= iam_d;
            rsp_iaf_q   <= iaf_d;
            rsp_instr_q <= (iam_d || iaf_d) ? 32'd0 : rd_word;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          // Flush takes precedence: the response is discarded even if fetch accepts it.
          if (flush_i || rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            if (flush_i) begin
              rsp_iam_q <= 1'b0;
              rsp_iaf_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_pc_o    = rsp_pc_q;
  assign rsp_instr_o = rsp_instr_q;
  assign rsp_iam_o   = rsp_iam_q;
  assign rsp_iaf_o   = rsp_iaf_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances (LATENCY 1, 4, 3) share all inputs;
// each scenario checks only the instance whose latency it targets.
module tb_imem_responder;

  localparam int L1 = 0;
  localparam int L4 = 1;
  localparam int L3 = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_ready;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic        rdy [3];
  logic        vld [3];
  logic [31:0] pc  [3];
  logic [31:0] ins [3];
  logic        iam [3];
  logic        iaf [3];

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] W0 = 32'h0000_0093;
  localparam logic [31:0] W1 = 32'h0010_0113;
  localparam logic [31:0] W2 = 32'h0020_8233;
  localparam logic [31:0] W4 = 32'h0040_0313;
  localparam logic [31:0] W8 = 32'h0080_0413;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_responder #(
      .BASE_ADDR  (32'h0000_0000),
      .DEPTH_WORDS(1024),
      .LATENCY    ((g == 0) ? 1 : (g == 1) ? 4 : 3)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_valid_i(req_valid),
      .req_addr_i (req_addr),
      .req_ready_o(rdy[g]),
      .flush_i    (flush),
      .rsp_valid_o(vld[g]),
      .rsp_ready_i(rsp_ready),
      .rsp_pc_o   (pc[g]),
      .rsp_instr_o(ins[g]),
      .rsp_iam_o  (iam[g]),
      .rsp_iaf_o  (iaf[g]),
      .ld_we_i    (ld_we),
      .ld_addr_i  (ld_addr),
      .ld_data_i  (ld_data)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [9:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rdy[i], vld[i], iam[i], iaf[i], pc[i], ins[i]} !== 68'd0) begin
        errors++;
        $display("FAIL reset_values[%0d]: got rdy=%b vld=%b iam=%b iaf=%b pc=%h instr=%h, want all zero",
                 i, rdy[i], vld[i], iam[i], iaf[i], pc[i], ins[i]);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (rdy[L1] !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", rdy[L1]);
    end
    load_word(10'd0, W0);
    load_word(10'd1, W1);
    load_word(10'd2, W2);
    load_word(10'd4, W4);
    load_word(10'd8, W8);
  endtask

  task automatic test_basic_fetch();
    logic [31:0] addrs [2];
    logic [31:0] words [2];
    addrs[0] = 32'h0; words[0] = W0;
    addrs[1] = 32'h4; words[1] = W1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1;
      req_addr  = addrs[k];
      tick();
      req_valid = 1'b0;
      checks++;
      if ({rdy[L1], vld[L1]} !== 2'b00) begin
        errors++;
        $display("FAIL basic_accept[%0d]: got rdy=%b vld=%b want 0 0", k, rdy[L1], vld[L1]);
      end
      tick();
      checks++;
      if ({vld[L1], pc[L1], ins[L1], iam[L1], iaf[L1]} !== {1'b1, addrs[k], words[k], 2'b00}) begin
        errors++;
        $display("FAIL basic_rsp[%0d]: got vld=%b pc=%h instr=%h iam=%b iaf=%b want 1 %h %h 0 0",
                 k, vld[L1], pc[L1], ins[L1], iam[L1], iaf[L1], addrs[k], words[k]);
      end
      tick();
      checks++;
      if ({vld[L1], rdy[L1]} !== 2'b01) begin
        errors++;
        $display("FAIL basic_done[%0d]: got vld=%b rdy=%b want 0 1", k, vld[L1], rdy[L1]);
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h8;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({vld[L1], rdy[L1], pc[L1], ins[L1], iam[L1], iaf[L1]} !== {2'b10, 32'h8, W2, 2'b00}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b pc=%h instr=%h iam=%b iaf=%b",
                 c, vld[L1], rdy[L1], pc[L1], ins[L1], iam[L1], iaf[L1]);
      end
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({vld[L1], rdy[L1]} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b want 0 1", vld[L1], rdy[L1]);
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [4];
    logic [1:0]  flags [4];
    addrs[0] = 32'h0000_0006; flags[0] = 2'b10;
    addrs[1] = 32'h0000_1000; flags[1] = 2'b01;
    addrs[2] = 32'h0000_1002; flags[2] = 2'b10;
    addrs[3] = 32'hFFFF_FFFC; flags[3] = 2'b01;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_addr  = addrs[k];
      tick();
      req_valid = 1'b0;
      tick();
      checks++;
      if ({vld[L1], pc[L1], ins[L1], iam[L1], iaf[L1]} !== {1'b1, addrs[k], 32'd0, flags[k]}) begin
        errors++;
        $display("FAIL fault[%0d]: got vld=%b pc=%h instr=%h iam=%b iaf=%b want 1 %h 0 %b",
                 k, vld[L1], pc[L1], ins[L1], iam[L1], iaf[L1], addrs[k], flags[k]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    int seen;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({rdy[L4], vld[L4]} !== 2'b10) begin
      errors++;
      $display("FAIL flush_wait: got rdy=%b vld=%b want 1 0", rdy[L4], vld[L4]);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (vld[L4] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_no_rsp: got %0d valid cycles want 0", seen);
    end

    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if ({vld[L4], ins[L4]} !== {1'b1, W4}) begin
      errors++;
      $display("FAIL flush_resp_setup: got vld=%b instr=%h want 1 %h", vld[L4], ins[L4], W4);
    end
    flush     = 1'b1;
    rsp_ready = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({vld[L4], rdy[L4], iam[L4], iaf[L4]} !== 4'b0100) begin
      errors++;
      $display("FAIL flush_resp: got vld=%b rdy=%b iam=%b iaf=%b want 0 1 0 0",
               vld[L4], rdy[L4], iam[L4], iaf[L4]);
    end

    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    checks++;
    if ({rdy[L4], vld[L4]} !== 2'b10) begin
      errors++;
      $display("FAIL flush_idle_block: got rdy=%b vld=%b want 1 0", rdy[L4], vld[L4]);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    checks++;
    if (rdy[L3] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_start: got rdy=%b want 1", rdy[L3]);
    end
    req_valid = 1'b1;
    req_addr  = 32'h20;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vld[L3], rdy[L3], pc[L3]} !== {2'b00, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid_async: got vld=%b rdy=%b pc=%h want 0 0 0", vld[L3], rdy[L3], pc[L3]);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (rdy[L3] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got rdy=%b want 1", rdy[L3]);
    end
    req_valid = 1'b1;
    req_addr  = 32'h20;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (vld[L3] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_early: got vld=%b want 0", vld[L3]);
    end
    tick();
    checks++;
    if ({vld[L3], pc[L3], ins[L3]} !== {1'b1, 32'h20, W8}) begin
      errors++;
      $display("FAIL reset_mid_refetch: got vld=%b pc=%h instr=%h want 1 00000020 %h",
               vld[L3], pc[L3], ins[L3], W8);
    end
    tick();
  endtask

  task automatic test_load_collision();
    rsp_ready = 1'b1;
    checks++;
    if (rdy[L1] !== 1'b1) begin
      errors++;
      $display("FAIL collision_start: got rdy=%b want 1", rdy[L1]);
    end
    req_valid = 1'b1;
    req_addr  = 32'h8;
    tick();
    req_valid = 1'b0;
    ld_we     = 1'b1;
    ld_addr   = 10'd2;
    ld_data   = 32'hDEAD_BEEF;
    tick();
    ld_we = 1'b0;
    checks++;
    if ({vld[L1], ins[L1]} !== {1'b1, W2}) begin
      errors++;
      $display("FAIL collision_old: got vld=%b instr=%h want 1 %h", vld[L1], ins[L1], W2);
    end
    tick();
    req_valid = 1'b1;
    req_addr  = 32'h8;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if ({vld[L1], ins[L1]} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL collision_new: got vld=%b instr=%h want 1 deadbeef", vld[L1], ins[L1]);
    end
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    ld_we     = 1'b0;
    ld_addr   = 10'd0;
    ld_data   = 32'd0;
    #2;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_faults();
    test_flush();
    test_reset_mid();
    test_load_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
